scan_chain_len_table: RTL and testbench
=======================================

SCAN_CHAIN_LEN_TABLE -- requirements
Module: scan_chain_len_table

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 16: number of table entries; range 2..64.
REQ-002 SHALL have parameter LEN_W, default 11: width of each chain-length entry.
REQ-003 SHALL have parameter ADDR_W, default 6: width of all chain-address ports; 2**ADDR_W >= NUM_CHAINS.
REQ-004 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1: write strobe.
REQ-007 SHALL have port wr_addr, input, ADDR_W: write address.
REQ-008 SHALL have port wr_data, input, LEN_W: chain length to write.
REQ-009 SHALL have port rd_addr, input, ADDR_W: host read address.
REQ-010 SHALL have port rd_data, output, LEN_W: registered host read data.
REQ-011 SHALL have port start, input, 1: one-cycle request to walk chains first_chain..last_chain.
REQ-012 SHALL have ports first_chain and last_chain, input, ADDR_W each: walk bounds, sampled on an accepted start.
REQ-013 SHALL have port shift_ready, input, 1: downstream TAP accepts one bit this cycle.
REQ-014 SHALL have port busy, output, 1: walker is not in IDLE.
REQ-015 SHALL have port shift_en, output, 1: one scan bit is transferred this cycle.
REQ-016 SHALL have port cur_chain, output, ADDR_W: chain being walked.
REQ-017 SHALL have port bits_left, output, LEN_W: bits remaining in cur_chain, including the current bit.
REQ-018 SHALL have ports chain_done and done, output, 1 each: one-cycle pulses at the end of a chain and at the end of the walk.
REQ-019 SHALL have port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-020 Write: when wr_en is high and wr_addr < NUM_CHAINS, the entry SHALL update at the clock edge; writes to out-of-range addresses SHALL be ignored.
REQ-021 Read latency SHALL be 1 cycle: rd_data reflects rd_addr from the previous cycle.
REQ-022 Read of an out-of-range address SHALL return 0.
REQ-023 Read and write to the same address in the same cycle SHALL be write-first: rd_data = wr_data.
REQ-024 The walker FSM SHALL have exactly the states IDLE, LOAD, SHIFT, NEXT and FIN.
REQ-025 IDLE + start: if first_chain > last_chain or last_chain >= NUM_CHAINS, the FSM SHALL pulse err and stay in IDLE; otherwise it SHALL latch the bounds, set cur_chain = first_chain and go to LOAD.
REQ-026 LOAD SHALL last 1 cycle and latch entry[cur_chain] into bits_left.
- Length 0: go to NEXT with no shift and no chain_done.
- Otherwise: go to SHIFT.
REQ-027 SHIFT: shift_en = shift_ready, combinational.
- Each cycle with shift_ready high, bits_left SHALL decrement.
- When bits_left == 1 and shift_ready is high, chain_done SHALL pulse in that cycle and the FSM SHALL go to NEXT.
- shift_ready low SHALL hold the state, with no decrement.
REQ-028 NEXT: if cur_chain == last_chain, go to FIN; else increment cur_chain and go to LOAD.
REQ-029 FIN SHALL last 1 cycle with done high, then return to IDLE.
REQ-030 A start outside IDLE SHALL be ignored, with no err.
REQ-031 Table writes during a walk SHALL be allowed.
- The walker SHALL use the value latched in LOAD.
- A write to a later chain, made before that chain's LOAD, SHALL take effect for the walk.
REQ-032 shift_en SHALL be low in every state other than SHIFT.
REQ-033 Host read and write ports SHALL stay fully functional while busy.

Reset
REQ-034 Reset SHALL initialise the table.
- entry[0] = 0.
- entry[i] = 13-i for 1 <= i <= min(8, NUM_CHAINS-1).
- All other entries = 0.
REQ-035 Reset SHALL set: FSM to IDLE; rd_data, bits_left and cur_chain to 0; busy, shift_en, chain_done, done and err low.
REQ-036 Reset SHALL take priority over wr_en and start.
REQ-037 Reset mid-walk SHALL abort the walk immediately, without done or chain_done.

Verification
REQ-038 After reset, reading addr 0..9 -> rd_data 0,12,11,10,9,8,7,6,5,0, each 1 cycle after the address.
REQ-039 wr_en with addr 3, data 0x7FF, and rd_addr 3 in the same cycle -> rd_data 0x7FF the next cycle; a write to addr 40 is ignored and a read of addr 40 returns 0.
REQ-040 start, first=1, last=2, shift_ready tied high -> response:
- 12 shift_en cycles on chain 1, then 11 on chain 2.
- chain_done with the 12th and with the 23rd shift.
- done exactly once.
- busy low the cycle after done.
REQ-041 Walk 8..10 with entries 9 and 10 = 0 -> 5 shifts on chain 8, chains 9 and 10 skipped with no shift_en and no chain_done, then done.
REQ-042 start with first=5, last=4 -> err pulse, busy stays low; start while busy -> ignored.
REQ-043 shift_ready toggled every other cycle on chain 8 -> exactly 5 shift_en cycles, bits_left 5..1; reset asserted mid-shift -> busy low and bits_left 0 the next cycle, no done.

Source files
------------

// File: rtl/scan_chain_len_table.sv
// Scan-chain length table with a host read/write port and a walker that
// streams one shift_en per scan bit for a contiguous range of chains.
module scan_chain_len_table #(
  parameter int NUM_CHAINS = 16,
  parameter int LEN_W      = 11,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_chain,
  input  logic [ADDR_W-1:0] last_chain,
  input  logic              shift_ready,
  output logic              busy,
  output logic              shift_en,
  output logic [ADDR_W-1:0] cur_chain,
  output logic [LEN_W-1:0]  bits_left,
  output logic              chain_done,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam logic [ADDR_W:0] NC = (ADDR_W+1)'(NUM_CHAINS);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEXT, FIN} state_t;

  logic [LEN_W-1:0]  tbl [NUM_CHAINS];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] last_q;
  logic              wr_ok, rd_ok, bounds_bad, accept;
  logic [LEN_W-1:0]  load_val;

  // Power-on table contents: chains 1..8 hold 12 down to 5, the rest empty.
  function automatic logic [LEN_W-1:0] init_val(input int i);
    return (i >= 1 && i <= 8) ? LEN_W'(13 - i) : '0;
  endfunction

  assign wr_ok      = wr_en && ({1'b0, wr_addr} < NC);
  assign rd_ok      = {1'b0, rd_addr} < NC;
  assign bounds_bad = (first_chain > last_chain) || ({1'b0, last_chain} >= NC);
  assign accept     = (state == IDLE) && start && !bounds_bad;
  // cur_chain is always a validated in-range index while the walker is active.
  assign load_val   = tbl[cur_chain[IDX_W-1:0]];

  // Table storage: reset loads the default lengths, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHAINS; i++) tbl[i] <= init_val(i);
    end else if (wr_ok) begin
      tbl[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Host read port: one-cycle latency, write-first on address collision.
  always_ff @(posedge clk) begin
    if (reset)                          rd_data <= '0;
    else if (!rd_ok)                    rd_data <= '0;
    else if (wr_ok && wr_addr == rd_addr) rd_data <= wr_data;
    else                                rd_data <= tbl[rd_addr[IDX_W-1:0]];
  end

  // Walker state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Walker next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = (load_val == '0) ? NEXT : SHIFT;
      SHIFT:   if (shift_ready && bits_left == LEN_W'(1)) state_nxt = NEXT;
      NEXT:    state_nxt = (cur_chain == last_chain_q()) ? FIN : LOAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [ADDR_W-1:0] last_chain_q();
    return last_q;
  endfunction

  // Walker counters: chain index, latched last bound and remaining bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_chain <= '0;
      last_q    <= '0;
      bits_left <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur_chain <= first_chain;
          last_q    <= last_chain;
        end
        LOAD:  bits_left <= load_val;
        SHIFT: if (shift_ready) bits_left <= bits_left - LEN_W'(1);
        NEXT:  if (cur_chain != last_q) cur_chain <= cur_chain + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Status and strobes; pulses are suppressed while reset is asserted.
  always_comb begin
    busy       = (state != IDLE);
    shift_en   = !reset && (state == SHIFT) && shift_ready;
    chain_done = shift_en && (bits_left == LEN_W'(1));
    done       = !reset && (state == FIN);
    err        = !reset && (state == IDLE) && start && bounds_bad;
  end

endmodule

// File: tb/tb_scan_chain_len_table.sv
// Directed bench for scan_chain_len_table: table reads/writes and walker runs.
module tb_scan_chain_len_table;

  logic        clk = 0;
  logic        reset = 0;
  logic        wr_en = 0;
  logic [5:0]  wr_addr = 0;
  logic [10:0] wr_data = 0;
  logic [5:0]  rd_addr = 0;
  logic [10:0] rd_data;
  logic        start = 0;
  logic [5:0]  first_chain = 0;
  logic [5:0]  last_chain = 0;
  logic        shift_ready = 0;
  logic        busy, shift_en, chain_done, done, err;
  logic [5:0]  cur_chain;
  logic [10:0] bits_left;

  int tests = 0;
  int fails = 0;

  // walk statistics
  int sh [64];
  int shifts, cd_cnt, done_cnt, done_cyc;
  int cd_pos [4];
  int bl_log [16];
  logic err_seen, err_first, busy_after, finished;

  scan_chain_len_table dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .first_chain(first_chain),
    .last_chain(last_chain), .shift_ready(shift_ready), .busy(busy), .shift_en(shift_en),
    .cur_chain(cur_chain), .bits_left(bits_left), .chain_done(chain_done), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; wr_en = 0; shift_ready = 0;
    tick();
    reset = 0;
  endtask

  // mode 1 toggles shift_ready; optional write at wcyc; optional extra start at icyc
  task automatic run_walk(input logic [5:0] f, input logic [5:0] l, input int mode,
                          input int wcyc, input logic [5:0] wa, input logic [10:0] wd,
                          input int icyc, input logic [5:0] inf, input logic [5:0] inl);
    for (int i = 0; i < 64; i++) sh[i] = 0;
    for (int i = 0; i < 16; i++) bl_log[i] = 0;
    shifts = 0; cd_cnt = 0; done_cnt = 0; done_cyc = -10;
    err_seen = 0; busy_after = 1; finished = 0;
    start = 1; first_chain = f; last_chain = l; shift_ready = (mode == 0);
    #1 err_first = err;
    tick();
    start = 0;
    for (int cyc = 1; cyc < 300 && !finished; cyc++) begin
      shift_ready = (mode == 0) ? 1'b1 : cyc[0];
      wr_en = (cyc == wcyc); wr_addr = wa; wr_data = wd;
      start = (cyc == icyc); 
      if (cyc == icyc) begin first_chain = inf; last_chain = inl; end
      #1;
      if (err) err_seen = 1;
      if (cyc == done_cyc + 1) begin busy_after = busy; finished = 1; end
      if (shift_en) begin
        sh[cur_chain]++;
        if (shifts < 16) bl_log[shifts] = bits_left;
        shifts++;
      end
      if (chain_done) begin
        if (cd_cnt < 4) cd_pos[cd_cnt] = shifts;
        cd_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      tick();
    end
    wr_en = 0; start = 0;
    tests++;
    if (!finished) begin fails++; $display("FAIL walk_timeout first=%0d last=%0d", f, l); end
  endtask

  task automatic test_reset();
    reset = 1; wr_en = 1; wr_addr = 1; wr_data = 11'h3FF; start = 1; first_chain = 1; last_chain = 1;
    tick();
    reset = 0; wr_en = 0; start = 0; rd_addr = 0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (bits_left !== 11'd0 || cur_chain !== 6'd0) begin fails++;
      $display("FAIL reset_regs bits_left=%0d cur_chain=%0d exp=0,0", bits_left, cur_chain); end
    tests++; if (rd_data !== 11'd0) begin fails++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    tests++; if ({shift_en, chain_done, done, err} !== 4'b0) begin fails++;
      $display("FAIL reset_pulses got=%b exp=0000", {shift_en, chain_done, done, err}); end
  endtask

  task automatic test_default_table();
    int exp_v [10] = '{0, 12, 11, 10, 9, 8, 7, 6, 5, 0};
    for (int i = 0; i < 10; i++) begin
      rd_addr = 6'(i);
      tick();
      tests++;
      if (rd_data !== 11'(exp_v[i])) begin fails++;
        $display("FAIL default_entry addr=%0d got=%0d exp=%0d", i, rd_data, exp_v[i]); end
    end
  endtask

  task automatic test_rw();
    wr_en = 1; wr_addr = 3; wr_data = 11'h7FF; rd_addr = 3;
    tick();
    wr_en = 0;
    tests++; if (rd_data !== 11'h7FF) begin fails++; $display("FAIL write_first got=%h exp=7ff", rd_data); end
    rd_addr = 2;
    tick();
    tests++; if (rd_data !== 11'd11) begin fails++; $display("FAIL neighbour_read got=%0d exp=11", rd_data); end
    rd_addr = 3;
    tick();
    tests++; if (rd_data !== 11'h7FF) begin fails++; $display("FAIL stored_write got=%h exp=7ff", rd_data); end
    wr_en = 1; wr_addr = 40; wr_data = 11'h123; rd_addr = 40;
    tick();
    wr_en = 0;
    tests++; if (rd_data !== 11'd0) begin fails++; $display("FAIL oob_read got=%0d exp=0", rd_data); end
    rd_addr = 8;
    tick();
    tests++; if (rd_data !== 11'd5) begin fails++; $display("FAIL oob_write_alias got=%0d exp=5", rd_data); end
  endtask

  task automatic test_walk_basic();
    do_reset();
    run_walk(1, 2, 0, -1, 0, 0, -1, 0, 0);
    tests++; if (sh[1] != 12 || sh[2] != 11) begin fails++;
      $display("FAIL walk_shifts ch1=%0d ch2=%0d exp=12,11", sh[1], sh[2]); end
    tests++; if (cd_cnt != 2 || cd_pos[0] != 12 || cd_pos[1] != 23) begin fails++;
      $display("FAIL walk_chain_done cnt=%0d pos=%0d,%0d exp=2 at 12,23", cd_cnt, cd_pos[0], cd_pos[1]); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL walk_done_count got=%0d exp=1", done_cnt); end
    tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL walk_busy_after_done got=%b exp=0", busy_after); end
    tests++; if (bl_log[0] != 12 || bl_log[11] != 1 || bl_log[12] != 11) begin fails++;
      $display("FAIL walk_bits_left got=%0d,%0d,%0d exp=12,1,11", bl_log[0], bl_log[11], bl_log[12]); end
  endtask

  task automatic test_zero_len();
    do_reset();
    run_walk(8, 10, 0, -1, 0, 0, -1, 0, 0);
    tests++; if (sh[8] != 5 || sh[9] != 0 || sh[10] != 0) begin fails++;
      $display("FAIL zero_len_shifts got=%0d,%0d,%0d exp=5,0,0", sh[8], sh[9], sh[10]); end
    tests++; if (cd_cnt != 1 || done_cnt != 1) begin fails++;
      $display("FAIL zero_len_pulses chain_done=%0d done=%0d exp=1,1", cd_cnt, done_cnt); end
  endtask

  task automatic test_midwalk_write();
    do_reset();
    run_walk(1, 2, 0, 3, 2, 11'd3, -1, 0, 0);
    tests++; if (sh[1] != 12 || sh[2] != 3) begin fails++;
      $display("FAIL midwalk_write ch1=%0d ch2=%0d exp=12,3", sh[1], sh[2]); end
  endtask

  task automatic test_err();
    do_reset();
    start = 1; first_chain = 5; last_chain = 4;
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_order got=%b exp=1", err); end
    tick();
    start = 0;
    #1;
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++;
      $display("FAIL err_after busy=%b err=%b exp=0,0", busy, err); end
    start = 1; first_chain = 3; last_chain = 16;
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_range got=%b exp=1", err); end
    tick();
    start = 0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_range_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_walk(1, 1, 0, -1, 0, 0, 4, 5, 4);
    tests++; if (err_seen !== 1'b0 || err_first !== 1'b0) begin fails++;
      $display("FAIL busy_start_err got=%b exp=0", err_seen); end
    run_walk(2, 2, 0, -1, 0, 0, 5, 3, 3);
    tests++; if (sh[2] != 11 || sh[3] != 0 || done_cnt != 1) begin fails++;
      $display("FAIL busy_start_ignored ch2=%0d ch3=%0d done=%0d exp=11,0,1", sh[2], sh[3], done_cnt); end
  endtask

  task automatic test_throttle_and_abort();
    do_reset();
    run_walk(8, 8, 1, -1, 0, 0, -1, 0, 0);
    tests++; if (shifts != 5) begin fails++; $display("FAIL throttle_shifts got=%0d exp=5", shifts); end
    tests++; if (bl_log[0] != 5 || bl_log[1] != 4 || bl_log[2] != 3 || bl_log[3] != 2 || bl_log[4] != 1) begin
      fails++; $display("FAIL throttle_bits_left got=%0d,%0d,%0d,%0d,%0d exp=5,4,3,2,1",
                        bl_log[0], bl_log[1], bl_log[2], bl_log[3], bl_log[4]); end
    // abort a walk partway through chain 1
    start = 1; first_chain = 1; last_chain = 2; shift_ready = 1;
    tick();
    start = 0;
    repeat (5) tick();
    reset = 1;
    #1;
    tests++; if (done !== 1'b0 || chain_done !== 1'b0) begin fails++;
      $display("FAIL abort_pulses done=%b chain_done=%b exp=0,0", done, chain_done); end
    tick();
    reset = 0;
    #1;
    tests++; if (busy !== 1'b0 || bits_left !== 11'd0) begin fails++;
      $display("FAIL abort_state busy=%b bits_left=%0d exp=0,0", busy, bits_left); end
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      #1 if (done || shift_en) done_cnt++;
      tick();
    end
    tests++; if (done_cnt != 0) begin fails++; $display("FAIL abort_quiet got=%0d exp=0", done_cnt); end
    shift_ready = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_default_table();
    test_rw();
    test_walk_basic();
    test_zero_len();
    test_midwalk_write();
    test_err();
    test_back_to_back();
    test_throttle_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
